multdiv_seq: RTL and testbench



---
 rtl/multdiv_pkg.sv | 8 +
 rtl/multdiv_counter.sv | 34 +++
 rtl/multdiv_seq.sv | 177 +++++++++++++++++
 tb/tb_multdiv_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int LATENCY       = DEFAULT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  typedef enum logic {OP_MUL, OP_DIV} op_e;
endpackage

// File: rtl/multdiv_counter.sv
// Modulo-WIDTH iteration counter with clear/enable and a terminal-count flag.
module multdiv_counter #(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 Booth) and divide (restoring) unit.
// Defining MULTDIV_REMAINDER_EN adds the signed data_remainder output.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
`ifdef MULTDIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              start_op;
  logic             last_q, last_d;
  logic             start, iter, tc;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH:0] prod_q, prod_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic [WIDTH:0]   hi_ext, booth_sum, div_shift, ovf;
  logic [WIDTH-1:0] b_mag;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] remout_q, remout_d;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start     = (state_q == IDLE) && (ctrl_MULT || ctrl_DIV);
  assign start_op  = ctrl_MULT ? OP_MUL : OP_DIV;
  assign iter      = ((state_q == MUL) || (state_q == DIV)) && !last_q;
  // Booth adder is one bit wider so subtracting INT_MIN cannot overflow.
  assign hi_ext    = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
  assign ovf       = prod_q[2*WIDTH:WIDTH];
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign b_mag     = mag(b_q);

  multdiv_counter #(.WIDTH(WIDTH)) u_counter (
    .clock  (clock),
    .resetn (resetn),
    .clr_i  (start),
    .en_i   (iter),
    .tc_o   (tc)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef MULTDIV_REMAINDER_EN
    remout_d = remout_q;
`endif
    case (prod_q[1:0])
      2'b01:   booth_sum = hi_ext + {a_q[WIDTH-1], a_q};
      2'b10:   booth_sum = hi_ext - {a_q[WIDTH-1], a_q};
      default: booth_sum = hi_ext;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (start_op == OP_MUL) ? MUL : DIV;
          last_d  = 1'b0;
          a_d     = data_operandA;
          b_d     = data_operandB;
          prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
          rem_d   = '0;
          quo_d   = mag(data_operandA);
        end
      end
      MUL, DIV: begin
        if (iter) begin
          last_d = tc;
          if (state_q == MUL) begin
            prod_d = {booth_sum, prod_q[WIDTH:1]};
          end else if (div_shift >= {1'b0, b_mag}) begin
            rem_d = div_shift[WIDTH-1:0] - b_mag;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Extra cycle after the last iteration: sign fixup and exception flags.
          state_d = DONE;
          last_d  = 1'b0;
          if (state_q == MUL) begin
            result_d = prod_q[WIDTH:1];
            exc_d    = !((&ovf) || !(|ovf));
`ifdef MULTDIV_REMAINDER_EN
            remout_d = '0;
`endif
          end else if (b_q == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            remout_d = a_q;
`endif
          end else if ((a_q == INT_MIN) && (b_q == '1)) begin
            result_d = INT_MIN;
            exc_d    = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            remout_d = '0;
`endif
          end else begin
            result_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_q : quo_q;
            exc_d    = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            remout_d = a_q[WIDTH-1] ? -rem_q : rem_q;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      remout_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_REMAINDER_EN
      remout_q <= remout_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign data_busy      = (state_q != IDLE);
`ifdef MULTDIV_REMAINDER_EN
  assign data_remainder = remout_q;
`endif
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq (WIDTH=32).
module tb_multdiv_seq;
  localparam int W = 32;
  // Negedge index of the ready cycle, counting the negedge right after the start edge as 1.
  localparam int RDY_CYC = 34;
  localparam int WIN = 40;

  logic         clock = 1'b0;
  logic         resetn;
  logic         ctrl_MULT, ctrl_DIV;
  logic [W-1:0] opA, opB;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, data_busy;
`ifdef MULTDIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
`ifdef MULTDIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  // Drive a start pulse for one edge, then scramble the operands.
  task automatic launch(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; opA = a; opB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; opA = 32'hDEAD_BEEF; opB = 32'h0000_0003;
  endtask

  task automatic observe(output int rdy_at, output int busy_cnt, output int pulses);
    rdy_at = -1; busy_cnt = 0; pulses = 0;
    for (int n = 1; n <= WIN; n++) begin
      @(negedge clock);
      if (data_busy) busy_cnt++;
      if (data_resultRDY) begin
        pulses++;
        if (rdy_at < 0) rdy_at = n;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; opA = '0; opB = '0;
    repeat (2) @(negedge clock);
    checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", data_result); end
    checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
    checks++; if (data_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", data_busy); end
    resetn = 1'b1;
    @(negedge clock);
    $display("reset: result=%h exc=%b rdy=%b busy=%b", data_result, data_exception, data_resultRDY, data_busy);
  endtask

  task automatic test_mul();
    logic [W-1:0] ta [5] = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] tb [5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] te [5] = '{32'hFFFF_FFEB, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};
    logic         tx [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int rdy_at, busy_cnt, pulses;
    for (int i = 0; i < 5; i++) begin
      launch(1'b1, 1'b0, ta[i], tb[i]);
      observe(rdy_at, busy_cnt, pulses);
      $display("mul %h*%h: result=%h exc=%b rdy_at=%0d busy=%0d pulses=%0d", ta[i], tb[i], data_result, data_exception, rdy_at, busy_cnt, pulses);
      checks++; if (data_result !== te[i]) begin failures++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, data_result, te[i]); end
      checks++; if (data_exception !== tx[i]) begin failures++; $display("FAIL mul_exc[%0d] got=%b exp=%b", i, data_exception, tx[i]); end
      checks++; if (rdy_at != RDY_CYC) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, rdy_at, RDY_CYC); end
      checks++; if (pulses != 1) begin failures++; $display("FAIL mul_rdy_pulses[%0d] got=%0d exp=1", i, pulses); end
      checks++; if (busy_cnt != RDY_CYC) begin failures++; $display("FAIL mul_busy_cycles[%0d] got=%0d exp=%0d", i, busy_cnt, RDY_CYC); end
`ifdef MULTDIV_REMAINDER_EN
      checks++; if (data_remainder !== 32'h0) begin failures++; $display("FAIL mul_remainder[%0d] got=%h exp=00000000", i, data_remainder); end
`endif
    end
  endtask

  task automatic test_div();
    logic [W-1:0] ta [6] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FF9C};
    logic [W-1:0] tb [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    logic [W-1:0] tq [6] = '{32'hFFFF_FFFD, 32'h0, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD, 32'd14};
    logic         tx [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef MULTDIV_REMAINDER_EN
    logic [W-1:0] tr [6] = '{32'hFFFF_FFFF, 32'd5, 32'h0, 32'd2, 32'd1, 32'hFFFF_FFFE};
`endif
    int rdy_at, busy_cnt, pulses;
    for (int i = 0; i < 6; i++) begin
      launch(1'b0, 1'b1, ta[i], tb[i]);
      observe(rdy_at, busy_cnt, pulses);
      $display("div %h/%h: result=%h exc=%b rdy_at=%0d busy=%0d", ta[i], tb[i], data_result, data_exception, rdy_at, busy_cnt);
      checks++; if (data_result !== tq[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, data_result, tq[i]); end
      checks++; if (data_exception !== tx[i]) begin failures++; $display("FAIL div_exc[%0d] got=%b exp=%b", i, data_exception, tx[i]); end
      checks++; if (rdy_at != RDY_CYC) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, rdy_at, RDY_CYC); end
      checks++; if (busy_cnt != RDY_CYC) begin failures++; $display("FAIL div_busy_cycles[%0d] got=%0d exp=%0d", i, busy_cnt, RDY_CYC); end
`ifdef MULTDIV_REMAINDER_EN
      checks++; if (data_remainder !== tr[i]) begin failures++; $display("FAIL div_remainder[%0d] got=%h exp=%h", i, data_remainder, tr[i]); end
`endif
    end
  endtask

  // Both starts high (multiply wins), then a DIV pulse mid-op and one in the DONE cycle.
  task automatic test_priority_ignore();
    int rdy_at = -1, busy_cnt = 0, pulses = 0;
    launch(1'b1, 1'b1, 32'd6, 32'd3);
    for (int n = 1; n <= WIN; n++) begin
      @(negedge clock);
      if (data_busy) busy_cnt++;
      if (data_resultRDY) begin
        pulses++;
        if (rdy_at < 0) rdy_at = n;
      end
      if (n == 10 || n == RDY_CYC) begin ctrl_DIV = 1'b1; opA = 32'd100; opB = 32'd7; end
      if (n == 11 || n == RDY_CYC + 1) ctrl_DIV = 1'b0;
    end
    $display("mul+div 6,3: result=%h exc=%b rdy_at=%0d busy=%0d pulses=%0d", data_result, data_exception, rdy_at, busy_cnt, pulses);
    checks++; if (data_result !== 32'd18) begin failures++; $display("FAIL prio_result got=%h exp=00000012", data_result); end
    checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL prio_exc got=%b exp=0", data_exception); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL prio_rdy_pulses got=%0d exp=1", pulses); end
    checks++; if (rdy_at != RDY_CYC) begin failures++; $display("FAIL prio_latency got=%0d exp=%0d", rdy_at, RDY_CYC); end
    checks++; if (busy_cnt != RDY_CYC) begin failures++; $display("FAIL prio_busy_cycles got=%0d exp=%0d", busy_cnt, RDY_CYC); end
  endtask

  task automatic test_reset_midop();
    int rdy_at, busy_cnt, pulses = 0;
    launch(1'b0, 1'b1, 32'd100, 32'd7);
    for (int n = 1; n <= WIN; n++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
      if (n == 15) begin
        resetn = 1'b0;
        #1;
        $display("reset mid-div: result=%h exc=%b rdy=%b busy=%b", data_result, data_exception, data_resultRDY, data_busy);
        checks++; if (data_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", data_busy); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", data_result); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL midreset_exc got=%b exp=0", data_exception); end
      end
      if (n == 16) resetn = 1'b1;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midreset_rdy_pulses got=%0d exp=0", pulses); end
    launch(1'b1, 1'b0, 32'd4, 32'd5);
    observe(rdy_at, busy_cnt, pulses);
    $display("mul 4*5 after reset: result=%h rdy_at=%0d", data_result, rdy_at);
    checks++; if (data_result !== 32'd20) begin failures++; $display("FAIL post_reset_result got=%h exp=00000014", data_result); end
    checks++; if (rdy_at != RDY_CYC) begin failures++; $display("FAIL post_reset_latency got=%0d exp=%0d", rdy_at, RDY_CYC); end
  endtask

  // DIV started in the first IDLE cycle after the MUL ready: one IDLE cycle plus a full op apart.
  task automatic test_back_to_back();
    int rdy1 = -1, rdy2 = -1, pulses = 0, hold_bad = 0;
    logic [W-1:0] res1 = '0, res2 = '0;
    launch(1'b1, 1'b0, 32'd3, 32'd3);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        pulses++;
        if (rdy1 < 0) begin rdy1 = n; res1 = data_result; end
        else if (rdy2 < 0) begin rdy2 = n; res2 = data_result; end
      end else if (rdy1 > 0 && rdy2 < 0 && data_result !== 32'd9) begin
        hold_bad++;
      end
      if (rdy1 > 0 && n == rdy1 + 1) begin ctrl_DIV = 1'b1; opA = 32'd9; opB = 32'd3; end
      if (rdy1 > 0 && n == rdy1 + 2) ctrl_DIV = 1'b0;
    end
    $display("b2b mul 3*3 -> %h @%0d, div 9/3 -> %h @%0d, pulses=%0d", res1, rdy1, res2, rdy2, pulses);
    checks++; if (res1 !== 32'd9) begin failures++; $display("FAIL b2b_mul_result got=%h exp=00000009", res1); end
    checks++; if (res2 !== 32'd3) begin failures++; $display("FAIL b2b_div_result got=%h exp=00000003", res2); end
    checks++; if (rdy1 != RDY_CYC) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", rdy1, RDY_CYC); end
    checks++; if (rdy2 - rdy1 != RDY_CYC + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", rdy2 - rdy1, RDY_CYC + 1); end
    checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_rdy_pulses got=%0d exp=2", pulses); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL b2b_result_hold got=%0d unstable cycles exp=0", hold_bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_priority_ignore();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
